lsu_data_if: RTL and testbench

Load/store interface between the core's memory stage and the data-memory port (req/gnt/rvalid protocol, single-cycle gnt, rvalid one cycle after grant, rvalid returned for writes too). Takes one load or store at a time from the pipeline and issues a word-aligned bus request with byte enables. Waits for grant and response, then returns size-extracted, sign/zero-extended load data. Stalls the pipeline while a transaction is in flight.

---
 rtl/lsu_data_if.sv | 172 +++++++++++++++++
 tb/tb_lsu_data_if.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_if.sv
// Load/store unit data-memory interface: one request at a time, req/gnt/rvalid bus.
// Ports: lsu_* pipeline side (req, we, size, sign_ext, addr, wdata / ready, rvalid, rdata, err);
//        data_* bus side (req, adr, write, write_enable, be / gnt, rvalid, read).
module lsu_data_if #(
  parameter int unsigned GNT_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_ready_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic [31:0] data_adr_o,
  output logic [31:0] data_write_o,
  output logic        data_write_enable_o,
  output logic [3:0]  data_be_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_read_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int CW =
    (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT + 1) : 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [1:0]    r_off;
  logic [31:0]   r_adr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_rvalid;
  logic          r_err;
  logic [31:0]   r_rdata;

  logic          w_legal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_sh_b;
  logic [31:0]   w_sh_h;
  logic [31:0]   w_ext;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_timeout;

  // Request decode: alignment, byte lanes, lane-replicated store data
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = '0;
    unique case (1'b1)
      (lsu_size_i == 2'b00): begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      (lsu_size_i == 2'b01): begin
        w_legal = ~lsu_addr_i[0];
        w_be    = 4'b0011 << lsu_addr_i[1:0];
        w_wdata = {2{lsu_wdata_i[15:0]}};
      end
      (lsu_size_i == 2'b10): begin
        w_legal = (lsu_addr_i[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
      end
      default: ;
    endcase
  end

  // Load extraction from the registered offset/size
  assign w_sh_b = data_read_i >> {r_off, 3'b000};
  assign w_sh_h = data_read_i >> {r_off[1], 4'b0000};

  always_comb begin
    w_ext = data_read_i;
    unique case (1'b1)
      (r_size == 2'b00):
        w_ext = {{24{r_sext & w_sh_b[7]}}, w_sh_b[7:0]};
      (r_size == 2'b01):
        w_ext = {{16{r_sext & w_sh_h[15]}}, w_sh_h[15:0]};
      default: ;
    endcase
  end

  // r_cnt holds the number of ungranted REQ cycles already seen
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_timeout = (GNT_TIMEOUT != 0) &&
                     (w_cnt_nxt == CW'(GNT_TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_off    <= 2'b00;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_be     <= 4'b0000;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (lsu_req_i) begin
            if (w_legal) begin
              r_we    <= lsu_we_i;
              r_size  <= lsu_size_i;
              r_sext  <= lsu_sign_ext_i;
              r_off   <= lsu_addr_i[1:0];
              r_adr   <= {lsu_addr_i[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
              r_state <= S_REQ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_we ? '0 : w_ext;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready_o         = (r_state == S_IDLE);
  assign lsu_rvalid_o        = r_rvalid;
  assign lsu_rdata_o         = r_rdata;
  assign lsu_err_o           = r_err;
  assign data_req_o          = (r_state == S_REQ);
  assign data_adr_o          = r_adr;
  assign data_write_o        = r_wdata;
  assign data_write_enable_o = r_we;
  assign data_be_o           = r_be;

endmodule

// File: tb/tb_lsu_data_if.sv
// Testbench for lsu_data_if: table vectors, directed corner cases,
// and random transactions checked against a byte-lane reference model.
module tb_lsu_data_if;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_size_i = 2'b00;
  logic        lsu_sign_ext_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_read_i = '0;

  logic        o0_ready, o0_rvalid, o0_err, o0_req, o0_we;
  logic [31:0] o0_rdata, o0_adr, o0_wr;
  logic [3:0]  o0_be;
  logic        o3_ready, o3_rvalid, o3_err, o3_req, o3_we;
  logic [31:0] o3_rdata, o3_adr, o3_wr;
  logic [3:0]  o3_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_data_if #(.GNT_TIMEOUT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_sign_ext_i(lsu_sign_ext_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(o0_ready), .lsu_rvalid_o(o0_rvalid),
    .lsu_rdata_o(o0_rdata), .lsu_err_o(o0_err),
    .data_req_o(o0_req), .data_adr_o(o0_adr),
    .data_write_o(o0_wr), .data_write_enable_o(o0_we),
    .data_be_o(o0_be), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_read_i(data_read_i)
  );

  lsu_data_if #(.GNT_TIMEOUT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_sign_ext_i(lsu_sign_ext_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(o3_ready), .lsu_rvalid_o(o3_rvalid),
    .lsu_rdata_o(o3_rdata), .lsu_err_o(o3_err),
    .data_req_o(o3_req), .data_adr_o(o3_adr),
    .data_write_o(o3_wr), .data_write_enable_o(o3_we),
    .data_be_o(o3_be), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_read_i(data_read_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          gw;
    logic        err;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] wr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic we, logic [1:0] size, logic sext,
    logic [31:0] addr, logic [31:0] wdata, logic [31:0] mem,
    int gw, logic err, logic [31:0] adr, logic [3:0] be,
    logic [31:0] wr, logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.sext = sext;
    v.addr = addr; v.wdata = wdata; v.mem = mem;
    v.gw = gw; v.err = err; v.adr = adr; v.be = be;
    v.wr = wr; v.rdata = rdata;
    return v;
  endfunction

  // Reference: lanes covered by the access, data replicated by lane
  // index modulo access width, loads shifted down then masked/extended.
  function automatic vec_t model(
    logic we, logic [1:0] size, logic sext,
    logic [31:0] addr, logic [31:0] wdata, logic [31:0] mem, int gw);
    vec_t r;
    int n;
    int off;
    logic [63:0] v;
    logic [63:0] mask;
    r = mk(we, size, sext, addr, wdata, mem, gw, 1'b0, '0, '0, '0, '0);
    off = int'(addr[1:0]);
    n = 1 << size;
    r.err = (size == 2'b11) || ((off % n) != 0);
    r.adr = addr & ~32'h3;
    if (!r.err) begin
      for (int k = 0; k < 4; k++) begin
        r.be[k] = (k >= off) && (k < off + n);
        r.wr[8*k +: 8] = wdata[8*(k % n) +: 8];
      end
      v = {32'h0, mem} >> (8 * off);
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (sext && v[8*n-1]) v = v | ~mask;
      r.rdata = we ? 32'h0 : v[31:0];
    end
    return r;
  endfunction

  task automatic do_txn(input vec_t v);
    lsu_req_i = 1'b1;
    lsu_we_i = v.we;
    lsu_size_i = v.size;
    lsu_sign_ext_i = v.sext;
    lsu_addr_i = v.addr;
    lsu_wdata_i = v.wdata;
    chk("ready_before", {31'h0, o0_ready}, 32'h1);
    tick();
    lsu_req_i = 1'b0;
    lsu_addr_i = $urandom;
    lsu_wdata_i = $urandom;
    lsu_size_i = 2'($urandom);
    lsu_we_i = 1'($urandom);
    if (v.err) begin
      chk("err_pulse", {31'h0, o0_err}, 32'h1);
      chk("err_noreq", {31'h0, o0_req}, 32'h0);
      chk("err_ready", {31'h0, o0_ready}, 32'h1);
      chk("err_norv", {31'h0, o0_rvalid}, 32'h0);
      tick();
      chk("err_clear", {31'h0, o0_err}, 32'h0);
      chk("err_noreq2", {31'h0, o0_req}, 32'h0);
      return;
    end
    for (int w = 0; w <= v.gw; w++) begin
      data_gnt_i = (w == v.gw);
      data_rvalid_i = 1'($urandom);
      data_read_i = $urandom;
      chk("req_high", {31'h0, o0_req}, 32'h1);
      chk("req_notready", {31'h0, o0_ready}, 32'h0);
      chk("req_norv", {31'h0, o0_rvalid}, 32'h0);
      chk("req_noerr", {31'h0, o0_err}, 32'h0);
      chk("adr", o0_adr, v.adr);
      chk("be", {28'h0, o0_be}, {28'h0, v.be});
      chk("we", {31'h0, o0_we}, {31'h0, v.we});
      if (v.we) chk("wdata", o0_wr, v.wr);
      tick();
    end
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_read_i = v.mem;
    chk("wait_noreq", {31'h0, o0_req}, 32'h0);
    chk("wait_notready", {31'h0, o0_ready}, 32'h0);
    tick();
    data_rvalid_i = 1'b0;
    data_read_i = $urandom;
    chk("rvalid", {31'h0, o0_rvalid}, 32'h1);
    chk("rdata", o0_rdata, v.rdata);
    chk("done_ready", {31'h0, o0_ready}, 32'h1);
    chk("done_noerr", {31'h0, o0_err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    vecs[0]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0,
                  0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'b00, 1, 32'h13, 32'h0, 32'h80FF1234, 0,
                  0, 32'h10, 4'h8, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk(0, 2'b01, 0, 32'h12, 32'h0, 32'h80FF1234, 1,
                  0, 32'h10, 4'hC, 32'h0, 32'h000080FF);
    vecs[3]  = mk(1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h12345678, 0,
                  0, 32'h20, 4'hC, 32'hABCDABCD, 32'h0);
    vecs[4]  = mk(1, 2'b00, 0, 32'h05, 32'h1234565A, 32'h0, 1,
                  0, 32'h04, 4'h2, 32'h5A5A5A5A, 32'h0);
    vecs[5]  = mk(0, 2'b01, 1, 32'h40, 32'h0, 32'h1234F00D, 0,
                  0, 32'h40, 4'h3, 32'h0, 32'hFFFFF00D);
    vecs[6]  = mk(0, 2'b00, 0, 32'h21, 32'h0, 32'h0000AB00, 2,
                  0, 32'h20, 4'h2, 32'h0, 32'h000000AB);
    vecs[7]  = mk(1, 2'b10, 0, 32'h100, 32'hCAFEF00D, 32'h0, 2,
                  0, 32'h100, 4'hF, 32'hCAFEF00D, 32'h0);
    vecs[8]  = mk(0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 0,
                  1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[9]  = mk(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 0,
                  1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[10] = mk(0, 2'b01, 1, 32'h31, 32'h0, 32'h0, 0,
                  1, 32'h0, 4'h0, 32'h0, 32'h0);
    vecs[11] = mk(0, 2'b01, 1, 32'h1E, 32'h0, 32'h7FFF0000, 0,
                  0, 32'h1C, 4'hC, 32'h0, 32'h00007FFF);
    vecs[12] = mk(0, 2'b00, 1, 32'h0A, 32'h0, 32'h00C30000, 0,
                  0, 32'h08, 4'h4, 32'h0, 32'hFFFFFFC3);

    // Reset values
    tick();
    tick();
    rst_ni = 1'b1;
    chk("rst_ready", {31'h0, o0_ready}, 32'h1);
    chk("rst_req", {31'h0, o0_req}, 32'h0);
    chk("rst_rvalid", {31'h0, o0_rvalid}, 32'h0);
    chk("rst_err", {31'h0, o0_err}, 32'h0);
    chk("rst_rdata", o0_rdata, 32'h0);
    chk("rst_adr", o0_adr, 32'h0);
    chk("rst_wr", o0_wr, 32'h0);
    chk("rst_we", {31'h0, o0_we}, 32'h0);
    chk("rst_be", {28'h0, o0_be}, 32'h0);
    chk("rst3_ready", {31'h0, o3_ready}, 32'h1);

    // Table vectors, issued back to back
    for (int i = 0; i < 13; i++) do_txn(vecs[i]);

    // Grant held off 4 cycles: dut0 waits, dut3 aborts after 3
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_size_i = 2'b10;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'h50;
    tick();
    lsu_req_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      data_gnt_i = (c == 5);
      chk("to0_req", {31'h0, o0_req}, 32'h1);
      chk("to0_adr", o0_adr, 32'h50);
      chk("to0_be", {28'h0, o0_be}, 32'hF);
      chk("to0_noerr", {31'h0, o0_err}, 32'h0);
      chk("to3_req", {31'h0, o3_req}, (c <= 3) ? 32'h1 : 32'h0);
      chk("to3_err", {31'h0, o3_err}, (c == 4) ? 32'h1 : 32'h0);
      chk("to3_ready", {31'h0, o3_ready}, (c >= 4) ? 32'h1 : 32'h0);
      chk("to3_norv", {31'h0, o3_rvalid}, 32'h0);
      tick();
    end
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_read_i = 32'h11223344;
    chk("to0_wait", {31'h0, o0_req}, 32'h0);
    tick();
    data_rvalid_i = 1'b0;
    chk("to0_rvalid", {31'h0, o0_rvalid}, 32'h1);
    chk("to0_rdata", o0_rdata, 32'h11223344);
    chk("to3_norv_end", {31'h0, o3_rvalid}, 32'h0);
    chk("to3_noerr_end", {31'h0, o3_err}, 32'h0);

    // Reset during WAIT_RV, late rvalid ignored
    lsu_req_i = 1'b1;
    lsu_size_i = 2'b10;
    lsu_we_i = 1'b0;
    lsu_addr_i = 32'h60;
    tick();
    lsu_req_i = 1'b0;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("mrst_req", {31'h0, o0_req}, 32'h0);
    chk("mrst_ready", {31'h0, o0_ready}, 32'h1);
    data_rvalid_i = 1'b1;
    data_read_i = 32'hFFFFFFFF;
    tick();
    data_rvalid_i = 1'b0;
    chk("mrst_norv", {31'h0, o0_rvalid}, 32'h0);
    chk("mrst_norv3", {31'h0, o3_rvalid}, 32'h0);
    chk("mrst_ready2", {31'h0, o0_ready}, 32'h1);
    chk("mrst_rdata", o0_rdata, 32'h0);
    do_txn(vecs[0]);

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data_rvalid_i = 1'b1;
        data_read_i = $urandom;
        tick();
        data_rvalid_i = 1'b0;
        chk("spurious_rv", {31'h0, o0_rvalid}, 32'h0);
      end
      rv = model(1'($urandom), 2'($urandom), 1'($urandom),
                 $urandom, $urandom, $urandom,
                 $urandom_range(0, 2));
      do_txn(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
